inst_fetch_ctrl: RTL
====================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning max in-flight plus buffered fetches (2..8).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port pc_valid  in  1  PC stage offers fetch address.
REQ-005 SHALL have port pc_addr  in  32  fetch address, word aligned.
REQ-006 SHALL have port pc_ready  out  1  address accepted this cycle (pc_valid && pc_ready).
REQ-007 SHALL have port inst_req  out  1  bus address-phase request.
REQ-008 SHALL have port inst_addr  out  32  bus address, stable while inst_req high.
REQ-009 SHALL have port inst_addr_ok  in  1  bus accepted address.
REQ-010 SHALL have port inst_data_ok  in  1  bus returns one instruction; never back-pressured.
REQ-011 SHALL have port inst_rdata  in  32  returned instruction.
REQ-012 SHALL have port out_valid  out  1  instruction available to decode.
REQ-013 SHALL have port out_pc  out  32  PC of presented instruction.
REQ-014 SHALL have port out_inst  out  32  presented instruction.
REQ-015 SHALL have port out_ready  in  1  decode consumes (out_valid && out_ready).
REQ-016 SHALL have port flush  in  1  redirect/exception; discard all older fetches.
REQ-017 SHALL have ports perf_wait_cnt, perf_drop_cnt  out  32 each  performance counters.

Function
REQ-018 SHALL run address FSM IDLE/REQ: IDLE->REQ on pc_valid && !flush && credit; REQ->IDLE on inst_addr_ok.
REQ-019 SHALL latch pc_addr into inst_addr on IDLE->REQ; pc_ready high exactly in that cycle; inst_req high only in REQ.
REQ-020 SHALL define credit as inflight + buf_count < DEPTH, evaluated in IDLE.
REQ-021 SHALL on inst_addr_ok push inst_addr into PC FIFO and increment inflight.
REQ-022 SHALL on inst_data_ok pop PC FIFO, decrement inflight; if drop_cnt>0 decrement drop_cnt and discard, else push {pc,inst} into response buffer.
REQ-023 SHALL present response-buffer head on out_pc/out_inst with out_valid = buffer non-empty; pop on out_valid && out_ready.
REQ-024 SHALL give first-fetch latency: data_ok in cycle N -> out_valid in cycle N+1.
REQ-025 SHALL on flush: clear response buffer; set drop_cnt = inflight - (inst_data_ok?1:0) + (REQ && inst_addr_ok?1:0) + pending drop_cnt adjustments, so every older response is discarded.
REQ-026 SHALL keep inst_req and inst_addr held if flush arrives in REQ; the request completes, and its later response is dropped.
REQ-027 SHALL ignore pc_valid in the flush cycle; the redirect address is accepted from the next cycle.
REQ-028 SHALL accept simultaneous push and pop on both FIFOs; full FIFO with simultaneous pop is legal.
REQ-029 SHALL count in perf_wait_cnt cycles with inflight>0, buffer empty and no data_ok, and in perf_drop_cnt every discarded response; both wrap modulo 2^32.

Reset
REQ-030 SHALL on resetn low immediately force IDLE, inflight=0, drop_cnt=0, FIFOs empty, inst_req=0, pc_ready=0, out_valid=0, inst_addr/out_pc/out_inst=0, counters=0.
REQ-031 SHALL treat reset mid-transaction as abandoning the bus; the bus is reset alongside.

Configuration
REQ-032 SHALL use macro INST_FETCH_PERFCNT_EN: when defined, counters per REQ-029; when undefined, counter logic is absent and perf outputs are constant 0.

Structure
REQ-033 SHALL place DEPTH default, the FSM state encoding and the counter width in the shared CPU package.
REQ-034 SHALL instantiate sub-module fetch_fifo (parameterised width/depth, synchronous FIFO with count) for PC FIFO and response buffer.

Verification
REQ-035 SHALL test: single fetch 0xBFC00000, addr_ok next cycle, data_ok +2 with 0x24080001 -> out_valid, out_pc 0xBFC00000, out_inst 0x24080001 one cycle after data_ok.
REQ-036 SHALL test: out_ready=0, DEPTH=2, three pc_valid -> only two accepted; third waits until one pop.
REQ-037 SHALL test: two inflight, flush, then redirect 0x80000180 -> both old responses dropped, perf_drop_cnt=2, only 0x80000180 presented.
REQ-038 SHALL test: flush while in REQ with addr_ok stalled 3 cycles -> inst_addr held stable, response dropped.
REQ-039 SHALL test: flush coincident with data_ok and out pop -> no stale out_valid next cycle, drop_cnt correct.
REQ-040 SHALL test: resetn asserted with two inflight -> all outputs zero without a clock edge; with macro undefined, perf outputs stay 0.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl_pkg: shared fetch-controller defaults, FSM encoding and counter width
package inst_fetch_ctrl_pkg;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W = 32;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count, clear, and head presented combinationally
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd, wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dout = mem[rd];

  // storage and pointers; a full FIFO may push and pop together since the head is read before the write lands
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch controller with credit-limited bus requests and flush drop tracking (perf counters under INST_FETCH_PERFCNT_EN)
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pc_valid,
  input  logic [31:0]      pc_addr,
  output logic             pc_ready,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] perf_wait_cnt,
  output logic [CNT_W-1:0] perf_drop_cnt
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  state_t        state, state_n;
  logic [CW-1:0] inflight, buf_count, drop_cnt, drop_n;
  logic          stale, stale_n;
  logic          credit, accept, push_pc, discard, push_rsp, pop_rsp;
  logic [31:0]   pc_head;
  logic [63:0]   rsp_head;

  // addresses accepted by the bus, awaiting their data
  fetch_fifo #(.W(32), .DEPTH(DEPTH)) pc_fifo (
    .clk(clk), .resetn(resetn), .clr(1'b0),
    .push(push_pc), .din(inst_addr),
    .pop(inst_data_ok), .dout(pc_head), .count(inflight)
  );

  // returned {pc, inst} pairs waiting for decode; emptied on flush
  fetch_fifo #(.W(64), .DEPTH(DEPTH)) rsp_fifo (
    .clk(clk), .resetn(resetn), .clr(flush),
    .push(push_rsp), .din({pc_head, inst_rdata}),
    .pop(pop_rsp), .dout(rsp_head), .count(buf_count)
  );

  assign pc_ready  = accept;
  assign inst_req  = (state == REQ);
  assign out_valid = (buf_count != '0);
  assign out_pc    = rsp_head[63:32];
  assign out_inst  = rsp_head[31:0];
  assign push_rsp  = inst_data_ok && !discard;
  assign pop_rsp   = out_valid && out_ready;

  // next state, handshake decode and drop bookkeeping; a flush re-arms drop_cnt to every response still owed by the bus
  always_comb begin
    credit  = ({1'b0, inflight} + {1'b0, buf_count}) < DEPTH_C;
    accept  = (state == IDLE) && pc_valid && !flush && credit;
    push_pc = (state == REQ) && inst_addr_ok;
    state_n = accept ? REQ : push_pc ? IDLE : state;
    discard = inst_data_ok && (flush || drop_cnt != '0);
    drop_n  = flush ? inflight + CW'(push_pc) - CW'(inst_data_ok)
                    : drop_cnt - CW'(inst_data_ok && drop_cnt != '0) + CW'(push_pc && stale);
    stale_n = (flush && state == REQ && !inst_addr_ok) ? 1'b1 : push_pc ? 1'b0 : stale;
  end

  // FSM state, latched bus address and pending-drop state; stale marks a request flushed before the bus took it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      inst_addr <= '0;
      drop_cnt  <= '0;
      stale     <= 1'b0;
    end else begin
      state    <= state_n;
      drop_cnt <= drop_n;
      stale    <= stale_n;
      if (accept) inst_addr <= pc_addr;
    end
  end

`ifdef INST_FETCH_PERFCNT_EN
  logic [CNT_W-1:0] wait_q, dropc_q;

  assign perf_wait_cnt = wait_q;
  assign perf_drop_cnt = dropc_q;

  // stall cycles waiting on the bus and discarded responses, both free-running
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_q  <= '0;
      dropc_q <= '0;
    end else begin
      wait_q  <= wait_q + CNT_W'(inflight != '0 && buf_count == '0 && !inst_data_ok);
      dropc_q <= dropc_q + CNT_W'(discard);
    end
  end
`else
  assign perf_wait_cnt = '0;
  assign perf_drop_cnt = '0;
`endif
endmodule
